// File: rtl/pc_target_unit_pkg.sv
// Shared widths and instruction field positions for the PC-target datapath.
package pc_target_unit_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned JTARGET_W = 26;

    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned JT_MSB  = 25;
    localparam int unsigned JT_LSB  = 0;
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] raw);
        return {{(XLEN-IMM_W){raw[IMM_W-1]}}, raw};
    endfunction

endpackage

// File: rtl/pc_add32.sv
// Combinational 32-bit unsigned adder with carry-out.
module pc_add32
    import pc_target_unit_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum,
    output logic            carry
);

    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/pc_target_unit.sv
// Computes sequential, jump, immediate and branch PC targets in parallel;
// results are registered and presented one cycle later with out_valid.
module pc_target_unit
    import pc_target_unit_pkg::*;
#(
    parameter logic [31:0] PC_INC       = 32'd1,
    parameter int unsigned JREGION_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] old_pc,
    input  logic [31:0] instr,
    output logic        out_valid,
    output logic [31:0] inc_pc,
    output logic        inc_carry,
    output logic [31:0] imm,
    output logic [31:0] bpc,
    output logic [31:0] jpc
);

    logic [XLEN-1:0] inc_pc_d;
    logic            inc_carry_d;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] bpc_d;
    logic [XLEN-1:0] jpc_d;
    logic            bpc_carry_unused;
    logic            unused_opcode;

    pc_add32 u_inc_add (
        .a     (old_pc),
        .b     (PC_INC),
        .sum   (inc_pc_d),
        .carry (inc_carry_d)
    );

    // Branch offset is relative to the incremented PC, not old_pc.
    pc_add32 u_branch_add (
        .a     (inc_pc_d),
        .b     (imm_d),
        .sum   (bpc_d),
        .carry (bpc_carry_unused)
    );

    always_comb begin
        imm_d = sext_imm(instr[IMM_MSB:IMM_LSB]);
        // Word-addressed: region bits merge with the target field, no shift.
        jpc_d = {old_pc[XLEN-1 -: JREGION_BITS], instr[JT_MSB:JT_LSB]};
    end

    assign unused_opcode = ^instr[OPC_MSB:OPC_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            inc_pc    <= '0;
            inc_carry <= 1'b0;
            imm       <= '0;
            bpc       <= '0;
            jpc       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                inc_pc    <= inc_pc_d;
                inc_carry <= inc_carry_d;
                imm       <= imm_d;
                bpc       <= bpc_d;
                jpc       <= jpc_d;
            end
        end
    end

endmodule

// File: tb/tb_pc_target_unit.sv
// Directed self-checking bench for pc_target_unit: vector table plus reset,
// hold and streaming sequences.
module tb_pc_target_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic        out_valid;
    logic [31:0] inc_pc;
    logic        inc_carry;
    logic [31:0] imm;
    logic [31:0] bpc;
    logic [31:0] jpc;

    int total;
    int bad;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] e_inc;
        logic        e_carry;
        logic [31:0] e_imm;
        logic [31:0] e_bpc;
        logic [31:0] e_jpc;
    } vec_t;

    vec_t vecs[6];

    pc_target_unit #(
        .PC_INC       (32'd1),
        .JREGION_BITS (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .old_pc    (old_pc),
        .instr     (instr),
        .out_valid (out_valid),
        .inc_pc    (inc_pc),
        .inc_carry (inc_carry),
        .imm       (imm),
        .bpc       (bpc),
        .jpc       (jpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".inc_pc"},    inc_pc,             32'd0);
        check({tag, ".inc_carry"}, {31'd0, inc_carry}, 32'd0);
        check({tag, ".imm"},       imm,                32'd0);
        check({tag, ".bpc"},       bpc,                32'd0);
        check({tag, ".jpc"},       jpc,                32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{32'h0000_0010, 32'h1000_0005, 32'h0000_0011, 1'b0, 32'h0000_0005, 32'h0000_0016, 32'h0000_0005};
        vecs[1] = '{32'h0000_0100, 32'h1000_FFFE, 32'h0000_0101, 1'b0, 32'hFFFF_FFFE, 32'h0000_00FF, 32'h0000_FFFE};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0BFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3] = '{32'h0000_0020, 32'h0800_0040, 32'h0000_0021, 1'b0, 32'h0000_0040, 32'h0000_0061, 32'h0000_0040};
        vecs[4] = '{32'hABCD_0000, 32'h03FF_8000, 32'hABCD_0001, 1'b0, 32'hFFFF_8000, 32'hABCC_8001, 32'hABFF_8000};
        vecs[5] = '{32'h7FFF_FFFF, 32'h0000_7FFF, 32'h8000_0000, 1'b0, 32'h0000_7FFF, 32'h8000_7FFF, 32'h7C00_7FFF};

        // Reset held with valid, random inputs across several edges.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        old_pc   = $urandom;
        instr    = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero($sformatf("reset%0d", i));
            old_pc = $urandom;
            instr  = $urandom;
        end

        // Release reset with valid asserted: first edge must capture.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            old_pc   = vecs[i].pc;
            instr    = vecs[i].ins;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d.inc_pc", i),    inc_pc,             vecs[i].e_inc);
            check($sformatf("v%0d.inc_carry", i), {31'd0, inc_carry}, {31'd0, vecs[i].e_carry});
            check($sformatf("v%0d.imm", i),       imm,                vecs[i].e_imm);
            check($sformatf("v%0d.bpc", i),       bpc,                vecs[i].e_bpc);
            check($sformatf("v%0d.jpc", i),       jpc,                vecs[i].e_jpc);
            @(negedge clk);
        end

        // Hold: capture, then drop in_valid with different inputs.
        old_pc   = 32'h0000_0020;
        instr    = 32'h0800_0040;
        in_valid = 1'b1;
        @(negedge clk);
        old_pc   = 32'h0000_0555;
        instr    = 32'h1234_8678;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d.out_valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("hold%0d.inc_pc", i),    inc_pc,             32'h0000_0021);
            check($sformatf("hold%0d.imm", i),       imm,                32'h0000_0040);
            check($sformatf("hold%0d.bpc", i),       bpc,                32'h0000_0061);
            check($sformatf("hold%0d.jpc", i),       jpc,                32'h0000_0040);
        end

        // Streaming: three back-to-back valid inputs.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            old_pc   = i;
            instr    = 32'h0000_0000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("stream%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream%0d.inc_pc", i),    inc_pc,             i + 1);
            @(negedge clk);
        end

        // Mid-cycle reset: outputs must clear without a clock edge.
        old_pc   = 32'hFFFF_FFFF;
        instr    = 32'h0BFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_async.inc_carry", {31'd0, inc_carry}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_async.out_valid", {31'd0, out_valid}, 32'd0);
        check("post_async.inc_pc", inc_pc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
